// File: rtl/toggle_rx_pkg.sv
// Shared types and constants for the toggle-coded serial receiver.
// Holds the framing FSM encoding, the framing bit values and the parity helper.
package toggle_rx_pkg;

    typedef enum logic [1:0] {
        IDLE   = 2'd0,
        DATA   = 2'd1,
        PARITY = 2'd2,
        STOP   = 2'd3
    } rx_state_t;

    localparam logic START_BIT = 1'b1;
    localparam logic STOP_BIT  = 1'b0;

    // Even parity bit: the value that makes the total count of ones even.
    function automatic logic even_parity(input logic [31:0] d);
        return ^d;
    endfunction

endpackage

// File: rtl/toggle_decode.sv
// toggle_decode: recovers the transmitted bit as line XOR previous line level.
// Latency: combinational; bit_dat is valid in the same cycle as bit_stb.
// Backpressure: none; every strobe yields one bit that must be consumed.
module toggle_decode (
    input  logic clk,
    input  logic rst,
    input  logic bit_en,
    input  logic line_in,
    output logic bit_dat,
    output logic bit_stb
);

    logic prev_line;

    // Reset captures the current level so no phantom toggle is seen afterwards.
    always_ff @(posedge clk) begin
        if (!rst) begin
            prev_line <= line_in;
        end else if (bit_en) begin
            prev_line <= line_in;
        end
    end

    assign bit_dat = line_in ^ prev_line;
    assign bit_stb = bit_en;

endmodule

// File: rtl/toggle_stream_rx.sv
// toggle_stream_rx: frames toggle-decoded bits into WIDTH-bit words (optional even parity: TOGGLE_RX_PARITY_EN).
// Latency: data_valid rises 1 clk after the stop-bit strobe.
// Backpressure: single holding register; a word completing while it is full and not being read is dropped (overrun).
module toggle_stream_rx
    import toggle_rx_pkg::*;
#(
    parameter int WIDTH = 8
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             bit_en,
    input  logic             line_in,
    output logic [WIDTH-1:0] data_out,
    output logic             data_valid,
    input  logic             data_ready,
    output logic             busy,
    output logic             frame_err,
    output logic             overrun
);

    localparam int             CW   = (WIDTH > 1) ? $clog2(WIDTH) : 1;
    localparam logic [CW-1:0]  LAST = CW'(WIDTH - 1);

    rx_state_t        state;
    rx_state_t        state_nxt;
    logic [CW-1:0]    cnt;
    logic [WIDTH-1:0] sreg;
    logic             par_err;
    logic             bit_dat;
    logic             bit_stb;
    logic             word_done;
    logic             stop_bad;

    toggle_decode u_decode (
        .clk     (clk),
        .rst     (rst),
        .bit_en  (bit_en),
        .line_in (line_in),
        .bit_dat (bit_dat),
        .bit_stb (bit_stb)
    );

    always_ff @(posedge clk) begin
        if (!rst) begin
            state <= IDLE;
        end else begin
            state <= state_nxt;
        end
    end

    always_comb begin
        state_nxt = state;
        word_done = 1'b0;
        stop_bad  = 1'b0;
        if (bit_stb) begin
            case (state)
                IDLE: begin
                    if (bit_dat == START_BIT) begin
                        state_nxt = DATA;
                    end
                end
                DATA: begin
                    if (cnt == LAST) begin
`ifdef TOGGLE_RX_PARITY_EN
                        state_nxt = PARITY;
`else
                        state_nxt = STOP;
`endif
                    end
                end
                PARITY: begin
                    state_nxt = STOP;
                end
                STOP: begin
                    // A bad stop bit is consumed here and never re-read as a start bit.
                    state_nxt = IDLE;
                    if (bit_dat == STOP_BIT && !par_err) begin
                        word_done = 1'b1;
                    end else begin
                        stop_bad = 1'b1;
                    end
                end
                default: begin
                    state_nxt = IDLE;
                end
            endcase
        end
    end

    always_ff @(posedge clk) begin
        if (!rst) begin
            cnt  <= '0;
            sreg <= '0;
        end else if (bit_stb) begin
            if (state == IDLE) begin
                cnt <= '0;
            end else if (state == DATA) begin
                sreg[cnt] <= bit_dat;
                cnt       <= cnt + 1'b1;
            end
        end
    end

`ifdef TOGGLE_RX_PARITY_EN
    always_ff @(posedge clk) begin
        if (!rst) begin
            par_err <= 1'b0;
        end else if (bit_stb) begin
            if (state == IDLE) begin
                par_err <= 1'b0;
            end else if (state == PARITY) begin
                par_err <= (bit_dat != even_parity(32'(sreg)));
            end
        end
    end
`else
    assign par_err = 1'b0;
`endif

    // Holding register: a read in the completion cycle frees the slot for the new word.
    always_ff @(posedge clk) begin
        if (!rst) begin
            data_out   <= '0;
            data_valid <= 1'b0;
            frame_err  <= 1'b0;
            overrun    <= 1'b0;
        end else begin
            frame_err <= stop_bad;
            overrun   <= 1'b0;
            if (word_done) begin
                if (!data_valid || data_ready) begin
                    data_out   <= sreg;
                    data_valid <= 1'b1;
                end else begin
                    overrun <= 1'b1;
                end
            end else if (data_valid && data_ready) begin
                data_valid <= 1'b0;
            end
        end
    end

    assign busy = (state != IDLE);

endmodule

// File: tb/tb_toggle_stream_rx.sv
// Bench for toggle_stream_rx: frame-level transmitter plus output-side reference model, checked every cycle.
module tb_toggle_stream_rx;

    localparam int WIDTH = 8;

    logic             clk = 1'b0;
    logic             rst;
    logic             bit_en;
    logic             line_in;
    logic [WIDTH-1:0] data_out;
    logic             data_valid;
    logic             data_ready;
    logic             busy;
    logic             frame_err;
    logic             overrun;

    toggle_stream_rx #(.WIDTH(WIDTH)) dut (
        .clk        (clk),
        .rst        (rst),
        .bit_en     (bit_en),
        .line_in    (line_in),
        .data_out   (data_out),
        .data_valid (data_valid),
        .data_ready (data_ready),
        .busy       (busy),
        .frame_err  (frame_err),
        .overrun    (overrun)
    );

    always #5 clk = ~clk;

    int n_checks = 0;
    int n_errors = 0;
    int cyc = 0;

    // Transmit-side annotations for the current cycle
    logic             f_start, f_done, f_bad;
    logic [WIDTH-1:0] f_word;
    logic             lvl;
    int               gap;
    int               ready_mode;
    int               stop_cyc;

    // Reference model of the outputs (state after the most recent posedge)
    logic             model_ok = 1'b0;
    logic             m_valid, m_fe, m_ov, m_busy;
    logic [WIDTH-1:0] m_data;

    // Observation counters
    int               n_vcyc = 0, n_hs = 0, n_fe = 0, n_ov = 0, n_busy = 0;
    int               rise_cyc = 0;
    logic [WIDTH-1:0] hs_data = '0;
    logic             prev_valid = 1'b0;

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_errors++;
            $display("FAIL %s: got %0h expected %0h (cycle %0d)", nm, act, exp, cyc);
        end
    endtask

    initial forever begin
        @(posedge clk);
        cyc++;
    end

    initial forever begin
        @(negedge clk);
        if (model_ok) begin
            chk("data_valid", 32'(data_valid), 32'(m_valid));
            chk("data_out",   32'(data_out),   32'(m_data));
            chk("frame_err",  32'(frame_err),  32'(m_fe));
            chk("overrun",    32'(overrun),    32'(m_ov));
            chk("busy",       32'(busy),       32'(m_busy));
            if (data_valid) n_vcyc++;
            if (data_valid && !prev_valid) rise_cyc = cyc;
            if (data_valid && data_ready) begin
                n_hs++;
                hs_data = data_out;
            end
            if (frame_err) n_fe++;
            if (overrun) n_ov++;
            if (busy) n_busy++;
            prev_valid = data_valid;
        end
        if (!rst) begin
            m_valid  = 1'b0;
            m_data   = '0;
            m_fe     = 1'b0;
            m_ov     = 1'b0;
            m_busy   = 1'b0;
            model_ok = 1'b1;
        end else begin
            m_fe = f_bad;
            m_ov = 1'b0;
            if (f_done) begin
                if (!m_valid || data_ready) begin
                    m_data  = f_word;
                    m_valid = 1'b1;
                end else begin
                    m_ov = 1'b1;
                end
            end else if (m_valid && data_ready) begin
                m_valid = 1'b0;
            end
            if (f_start) m_busy = 1'b1;
            else if (f_done || f_bad) m_busy = 1'b0;
        end
    end

    function automatic logic pick_ready();
        if (ready_mode == 0) return 1'b1;
        if (ready_mode == 1) return 1'b0;
        return logic'($urandom_range(0, 1));
    endfunction

    task automatic send_cycle(input logic en, input logic b, input logic st,
                              input logic dn, input logic bd, input logic [WIDTH-1:0] w);
        logic glitch;
        @(posedge clk);
        #1;
        rst = 1'b1;
        if (en) lvl = lvl ^ b;
        glitch     = !en && ($urandom_range(0, 3) == 0);
        line_in    = lvl ^ glitch;
        bit_en     = en;
        f_start    = st;
        f_done     = dn;
        f_bad      = bd;
        f_word     = w;
        data_ready = pick_ready();
        if (dn || bd) stop_cyc = cyc;
    endtask

    task automatic send_bit(input logic b, input logic st, input logic dn,
                            input logic bd, input logic [WIDTH-1:0] w);
        repeat (gap - 1) send_cycle(1'b0, 1'b0, 1'b0, 1'b0, 1'b0, '0);
        send_cycle(1'b1, b, st, dn, bd, w);
    endtask

    task automatic idle_bits(input int n);
        repeat (n) send_bit(1'b0, 1'b0, 1'b0, 1'b0, '0);
    endtask

    task automatic do_reset();
        @(posedge clk);
        #1;
        rst        = 1'b0;
        lvl        = logic'($urandom_range(0, 1));
        line_in    = lvl;
        bit_en     = logic'($urandom_range(0, 1));
        f_start    = 1'b0;
        f_done     = 1'b0;
        f_bad      = 1'b0;
        data_ready = pick_ready();
    endtask

    task automatic send_frame(input logic [WIDTH-1:0] w, input logic bad_stop,
                              input logic bad_par, input int abort_at);
        logic bp;
`ifdef TOGGLE_RX_PARITY_EN
        bp = bad_par;
`else
        bp = 1'b0;
`endif
        send_bit(1'b1, 1'b1, 1'b0, 1'b0, '0);
        for (int i = 0; i < WIDTH; i++) begin
            if (i == abort_at) begin
                do_reset();
                return;
            end
            send_bit(w[i], 1'b0, 1'b0, 1'b0, '0);
        end
`ifdef TOGGLE_RX_PARITY_EN
        send_bit((^w) ^ bp, 1'b0, 1'b0, 1'b0, '0);
`endif
        if (bad_stop || bp) send_bit(bad_stop, 1'b0, 1'b0, 1'b1, '0);
        else                send_bit(1'b0, 1'b0, 1'b1, 1'b0, w);
    endtask

    initial begin
        int b_v, b_h, b_f, b_o, b_b;
        rst        = 1'b0;
        bit_en     = 1'b0;
        lvl        = 1'b1;
        line_in    = 1'b1;
        data_ready = 1'b1;
        f_start    = 1'b0;
        f_done     = 1'b0;
        f_bad      = 1'b0;
        f_word     = '0;
        gap        = 2;
        ready_mode = 0;
        stop_cyc   = 0;

        // Reset with the line high, then an idle line
        @(posedge clk);
        #1;
        chk("reset data_valid", 32'(data_valid), 32'd0);
        chk("reset data_out",   32'(data_out),   32'd0);
        b_v = n_vcyc; b_f = n_fe; b_b = n_busy;
        idle_bits(20);
        chk("idle valid cycles", 32'(n_vcyc - b_v), 32'd0);
        chk("idle frame_err",    32'(n_fe - b_f),   32'd0);
        chk("idle busy cycles",  32'(n_busy - b_b), 32'd0);

        // Single word, strobe every 4 clocks, consumer always ready
        gap = 4; ready_mode = 0;
        b_v = n_vcyc; b_h = n_hs;
        send_frame(8'hA5, 1'b0, 1'b0, -1);
        idle_bits(3);
        chk("A5 handshakes",   32'(n_hs - b_h),       32'd1);
        chk("A5 valid cycles", 32'(n_vcyc - b_v),     32'd1);
        chk("A5 data",         32'(hs_data),          32'h A5);
        chk("A5 latency",      32'(rise_cyc - stop_cyc), 32'd1);
        chk("A5 model data",   32'(m_data),           32'h A5);

        // Two back-to-back words with the consumer stalled
        gap = 2; ready_mode = 1;
        b_o = n_ov;
        send_frame(8'h3C, 1'b0, 1'b0, -1);
        send_frame(8'h00, 1'b0, 1'b0, -1);
        idle_bits(2);
        chk("stall data_out",  32'(data_out),     32'h3C);
        chk("stall valid",     32'(data_valid),   32'd1);
        chk("stall overruns",  32'(n_ov - b_o),   32'd1);
        ready_mode = 0;
        idle_bits(2);

        // Bad stop bit, one bit per clock
        gap = 1;
        b_v = n_vcyc; b_f = n_fe;
        send_frame(8'hFF, 1'b1, 1'b0, -1);
        idle_bits(2);
        chk("badstop frame_err", 32'(n_fe - b_f),   32'd1);
        chk("badstop valid",     32'(n_vcyc - b_v), 32'd0);
        chk("badstop busy",      32'(busy),         32'd0);

        // Reset after the 4th data bit, then a clean frame
        gap = 3;
        b_h = n_hs;
        send_frame(8'h5A, 1'b0, 1'b0, 4);
        idle_bits(2);
        send_frame(8'h81, 1'b0, 1'b0, -1);
        idle_bits(3);
        chk("abort handshakes", 32'(n_hs - b_h), 32'd1);
        chk("abort data",       32'(hs_data),    32'h81);

`ifdef TOGGLE_RX_PARITY_EN
        gap = 2;
        b_f = n_fe; b_h = n_hs;
        send_frame(8'h07, 1'b0, 1'b1, -1);
        idle_bits(2);
        chk("parity bad frame_err", 32'(n_fe - b_f), 32'd1);
        chk("parity bad delivered", 32'(n_hs - b_h), 32'd0);
        send_frame(8'h07, 1'b0, 1'b0, -1);
        idle_bits(2);
        chk("parity good delivered", 32'(n_hs - b_h), 32'd1);
        chk("parity good data",      32'(hs_data),    32'h07);
`endif

        // Randomized traffic against the model
        for (int k = 0; k < 200; k++) begin
            logic [WIDTH-1:0] w;
            logic             bs, bpar;
            int               ab;
            w          = WIDTH'($urandom);
            gap        = $urandom_range(1, 4);
            ready_mode = $urandom_range(0, 2);
            bs         = ($urandom_range(0, 7) == 0);
            bpar       = ($urandom_range(0, 7) == 0);
            ab         = ($urandom_range(0, 9) == 0) ? $urandom_range(0, WIDTH - 1) : -1;
            send_frame(w, bs, bpar, ab);
            idle_bits($urandom_range(0, 2));
        end

        ready_mode = 0;
        gap = 2;
        idle_bits(4);
        chk("final busy",  32'(busy),       32'd0);
        chk("final valid", 32'(data_valid), 32'd0);

        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end

endmodule
